// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Serial receive front end. The raw RX pin is synchronised to clk, and 8N1
// frames are deserialised at a fixed baud divisor. Good bytes are buffered in
// a first-word-fall-through FIFO that the core drains with rd_en.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (must be >= 4)
//   DEPTH_LOG2   : FIFO depth is 2**DEPTH_LOG2 entries
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rxd        in   raw serial line, idle high, asynchronous to clk
//   rd_en      in   pop request, honoured only while valid=1
//   clr_err    in   synchronous clear of overrun / frame_err
//   dout       out  FIFO head byte (0 while empty)
//   valid      out  FIFO non-empty
//   count      out  FIFO occupancy, 0 .. 2**DEPTH_LOG2
//   overrun    out  sticky: good byte dropped because FIFO was full
//   frame_err  out  sticky: stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rxd,
   input  logic                rd_en,
   input  logic                clr_err,
   output logic [7:0]          dout,
   output logic                valid,
   output logic [DEPTH_LOG2:0] count,
   output logic                overrun,
   output logic                frame_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int OCC_W = DEPTH_LOG2 + 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // Synchroniser
   logic rx_meta_q;
   logic rx_s_q;

   // Receiver FSM and datapath
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             stop_good;
   logic             stop_bad;

   // FIFO
   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      count_q, count_d;
   logic                  fifo_full;
   logic                  fifo_valid;
   logic                  push;
   logic                  pop;

   // Error flags
   logic overrun_q, overrun_d;
   logic frame_err_q, frame_err_d;
   logic ovr_set;

   // ------------------------------------------------------------------------
   // Two-flop synchroniser; resets to the idle (high) line level so a reset
   // never looks like a start bit by itself.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rxd;
         rx_s_q    <= rx_meta_q;
      end
   end

   // ------------------------------------------------------------------------
   // Receiver FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // ------------------------------------------------------------------------
   // Receiver FSM: next state and sample strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      stop_good = 1'b0;
      stop_bad  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = '0;
               state_d = S_START;
            end
         end

         S_START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};  // LSB arrives first
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  stop_good = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_BREAK: begin
            // Hold off until the line returns high so a stuck-low line does
            // not generate a stream of 0x00 frames.
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FIFO control. A pop in the same cycle as a push into a full FIFO frees
   // the slot the push needs, so the byte is kept rather than dropped.
   // ------------------------------------------------------------------------
   assign fifo_valid = (count_q != '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign pop        = rd_en && fifo_valid;
   assign push       = stop_good && (!fifo_full || pop);
   assign ovr_set    = stop_good && fifo_full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; dout is masked while empty instead.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky error flags; a set event outranks a simultaneous clear.
   // ------------------------------------------------------------------------
   always_comb begin
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (clr_err) begin
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      if (ovr_set) begin
         overrun_d = 1'b1;
      end
      if (stop_bad) begin
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign dout      = fifo_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign valid     = fifo_valid;
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo at CLKS_PER_BIT=16, DEPTH_LOG2=4.
// Every good frame sent pushes its byte onto a reference queue; every pop
// compares the DUT head against the front of that queue.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int CPB = 16;
   localparam int DL  = 4;
   localparam int FRAME_C = 10 * CPB;
   // Cycle (counted in falling edges from the start-bit drive) that precedes
   // the rising edge where the receiver samples the stop bit: two synchroniser
   // cycles, one IDLE->START cycle, half a bit, then nine full bits.
   localparam int STOP_C  = 2 + CPB / 2 + 9 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxd;
   logic          rd_en;
   logic          clr_err;
   logic [7:0]    dout;
   logic          valid;
   logic [DL:0]   count;
   logic          overrun;
   logic          frame_err;

   int            total = 0;
   int            bad   = 0;
   logic [7:0]    sb_q [$];
   logic          exp_ovr;
   logic          exp_ferr;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH_LOG2   (DL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .dout      (dout),
      .valid     (valid),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drive one full 8N1 frame, starting and ending on a falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic pop_at_stop, input logic chk_timing);
      int slot;
      for (int c = 0; c < FRAME_C; c++) begin
         slot = c / CPB;
         if (slot == 0)      rxd = 1'b0;
         else if (slot <= 8) rxd = b[slot-1];
         else                rxd = stop_bit;
         rd_en = 1'b0;
         if (c == STOP_C) begin
            if (chk_timing) chk("pre_push_valid", 32'(valid), 0);
            if (pop_at_stop) begin
               if (sb_q.size() == 0) begin
                  chk("stop_pop_empty_valid", 32'(valid), 0);
               end else begin
                  chk("stop_pop_dout", 32'(dout), 32'(sb_q[0]));
                  void'(sb_q.pop_front());
                  rd_en = 1'b1;
               end
            end
         end
         if (chk_timing && c == STOP_C + 1) begin
            chk("push_valid", 32'(valid), 1);
            chk("push_count", 32'(count), 1);
            chk("push_dout", 32'(dout), 32'(b));
         end
         @(negedge clk);
      end
      rd_en = 1'b0;
      if (stop_bit) begin
         if (sb_q.size() < (1 << DL)) sb_q.push_back(b);
         else                         exp_ovr = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
   endtask

   task automatic pop_one(input string tag);
      logic [7:0] exp_b;
      if (sb_q.size() == 0) begin
         chk({tag, "_empty_valid"}, 32'(valid), 0);
      end else begin
         exp_b = sb_q.pop_front();
         chk({tag, "_valid"}, 32'(valid), 1);
         chk(tag, 32'(dout), 32'(exp_b));
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
         chk({tag, "_count"}, 32'(count), 32'(sb_q.size()));
      end
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
      chk({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err  = 1'b0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      rxd      = 1'b1;
      rd_en    = 1'b0;
      clr_err  = 1'b0;
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_valid", 32'(valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_dout", 32'(dout), 0);
      check_flags("rst");
      rst = 1'b0;
      idle(5);

      // Single byte with push timing
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      pop_one("single");
      chk("single_empty_valid", 32'(valid), 0);
      chk("single_empty_count", 32'(count), 0);

      // Back-to-back frames, no idle gap
      send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      chk("b2b_count", 32'(count), 3);
      pop_one("b2b0");
      pop_one("b2b1");
      pop_one("b2b2");
      check_flags("b2b");

      // Short glitch is rejected at the start-bit check
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle(40);
      chk("glitch_count", 32'(count), 0);
      chk("glitch_valid", 32'(valid), 0);
      check_flags("glitch");

      // Frame error followed by a held-low line, then recovery
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      idle(20);
      chk("ferr_count", 32'(count), 0);
      check_flags("ferr");
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      chk("ferr_next_dout", 32'(dout), 32'h12);
      check_flags("ferr_next");
      pulse_clr();
      check_flags("ferr_clr");
      pop_one("ferr_pop");

      // Overflow: 17 bytes into a 16-deep FIFO, no reads
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      chk("ovf_count", 32'(count), 16);
      chk("ovf_dout", 32'(dout), 0);
      check_flags("ovf");
      for (int i = 0; i < 16; i++) pop_one("ovf_pop");
      chk("ovf_drained_valid", 32'(valid), 0);
      pulse_clr();
      check_flags("ovf_clr");

      // Overflow averted by a pop on the 17th stop-sample edge
      for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      send_frame(8'h10, 1'b1, 1'b1, 1'b0);
      chk("ovf_pop_count", 32'(count), 16);
      check_flags("ovf_pop");
      for (int i = 0; i < 16; i++) pop_one("ovf_pop_drain");
      chk("ovf_pop_drained_valid", 32'(valid), 0);

      // Async reset mid-DATA with two bytes queued
      send_frame(8'h21, 1'b1, 1'b0, 1'b0);
      send_frame(8'h42, 1'b1, 1'b0, 1'b0);
      chk("arst_pre_count", 32'(count), 2);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_valid", 32'(valid), 0);
      sb_q.delete();
      exp_ovr  = 1'b0;
      exp_ferr = 1'b0;
      check_flags("arst");
      rxd = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(10);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      chk("arst_next_dout", 32'(dout), 32'h81);
      pop_one("arst_pop");
      check_flags("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
